alu_seq_exec: RTL and testbench

//  Execution-side consumer of the 4-bit ALU control code emitted by the ALU controller.

---
 rtl/alu_defs.sv | 54 +++++
 rtl/alu_seq_exec_if.sv | 27 ++
 rtl/alu_shifter.sv | 40 ++++
 rtl/alu_seq_exec.sv | 101 ++++++++++
 tb/tb_alu_seq_exec.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared ALU control codes, FSM states and combinational op helpers
// Imported by every file of the alu_seq_exec slice.
package alu_defs;

  localparam int DW  = 32;
  localparam int SHW = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_BNE  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SRAV = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SRA) || (code == ALU_SRAV);
  endfunction

  function automatic logic is_legal(input logic [3:0] code);
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_BNE,
      ALU_SLTU, ALU_SLT, ALU_SRA, ALU_SRAV, ALU_LUI: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  // Single-cycle ops; shift codes return src2 (the shift-by-zero result).
  function automatic logic [DW-1:0] alu_comb(input logic [3:0] code,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    case (code)
      ALU_AND:           return a & b;
      ALU_OR:            return a | b;
      ALU_ADD:           return a + b;
      ALU_SUB, ALU_BNE:  return a - b;
      ALU_SLTU:          return {{(DW-1){1'b0}}, (a < b)};
      ALU_SLT:           return {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SRA, ALU_SRAV: return b;
      ALU_LUI:           return {b[15:0], 16'h0000};
      default:           return '0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// rtl/alu_seq_exec_if.sv - request/response handshake bundle of alu_seq_exec
// slave modport is the execution unit, master is the issuing datapath.
interface alu_seq_exec_if;
  import alu_defs::*;

  logic            in_valid_i;
  logic            in_ready_o;
  logic [3:0]      ctrl_i;
  logic [DW-1:0]   src1_i;
  logic [DW-1:0]   src2_i;
  logic [SHW-1:0]  shamt_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [DW-1:0]   result_o;
  logic            zero_o;
  logic            illegal_o;

  modport slave (
    input  in_valid_i, ctrl_i, src1_i, src2_i, shamt_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o, illegal_o
  );

  modport master (
    output in_valid_i, ctrl_i, src1_i, src2_i, shamt_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o, illegal_o
  );
endinterface

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - arithmetic right shifter, iterative 1 bit/cycle or barrel
// ALU_SEQ_BARREL_EN selects the single-cycle barrel form (shifted is combinational, last=1).
module alu_shifter
  import alu_defs::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [DW-1:0]  load_value,
  input  logic [SHW-1:0] load_count,
  output logic [DW-1:0]  shifted,
  output logic           last
);

`ifdef ALU_SEQ_BARREL_EN
  assign shifted = $signed(load_value) >>> load_count;
  assign last    = 1'b1;
`else
  logic [DW-1:0]  value;
  logic [SHW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      count <= '0;
    end else if (load) begin
      value <= load_value;
      count <= load_count;
    end else if (count != '0) begin
      value <= shifted;
      count <= count - SHW'(1);
    end
  end

  // shifted is the value after this cycle's step; last marks the final step.
  assign shifted = $signed(value) >>> 1;
  assign last    = (count == SHW'(1));
`endif

endmodule

// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - handshaked ALU execution unit with iterative sra/srav
// ALU_SEQ_BARREL_EN makes shifts single-cycle; otherwise they take one cycle per bit.
module alu_seq_exec
  import alu_defs::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  alu_seq_exec_if.slave bus
);

  state_t         state, state_n;
  logic           accept, op_shift, sh_load, sh_last;
  logic           load_res, ill_d, bne_d, zero_d;
  logic [SHW-1:0] sh_amt;
  logic [DW-1:0]  sh_out, res_d, result_q;
  logic           zero_q, illegal_q;

  assign accept   = bus.in_valid_i && (state == ST_IDLE);
  assign op_shift = is_shift(bus.ctrl_i);
  assign sh_amt   = (bus.ctrl_i == ALU_SRA) ? bus.shamt_i : bus.src1_i[SHW-1:0];
  assign sh_load  = accept && op_shift;

  alu_shifter u_shifter (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .load       (sh_load),
    .load_value (bus.src2_i),
    .load_count (sh_amt),
    .shifted    (sh_out),
    .last       (sh_last)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    load_res = 1'b0;
    res_d    = result_q;
    ill_d    = illegal_q;
    bne_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load_res = 1'b1;
          res_d    = alu_comb(bus.ctrl_i, bus.src1_i, bus.src2_i);
          ill_d    = !is_legal(bus.ctrl_i);
          bne_d    = (bus.ctrl_i == ALU_BNE);
          state_n  = ST_DONE;
          if (op_shift) begin
`ifdef ALU_SEQ_BARREL_EN
            res_d = sh_out;
`else
            // Zero-length shifts skip SHIFT; alu_comb already returned src2.
            if (sh_amt != '0) begin
              load_res = 1'b0;
              state_n  = ST_SHIFT;
            end
`endif
          end
        end
      end
      ST_SHIFT: begin
        if (sh_last) begin
          load_res = 1'b1;
          res_d    = sh_out;
          ill_d    = 1'b0;
          state_n  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // bne reports "not equal" on the zero flag so branch logic stays uniform.
  assign zero_d = bne_d ? (res_d != '0) : (res_d == '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (load_res) begin
      result_q  <= res_d;
      zero_q    <= zero_d;
      illegal_q <= ill_d;
    end
  end

  assign bus.in_ready_o  = (state == ST_IDLE);
  assign bus.out_valid_o = (state == ST_DONE);
  assign bus.result_o    = result_q;
  assign bus.zero_o      = zero_q;
  assign bus.illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - randomized self-checking bench for alu_seq_exec
// Reference model computes results, flags and latency straight from the op definitions.
module tb_alu_seq_exec;
  import alu_defs::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  alu_seq_exec_if bus ();

  alu_seq_exec dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] s, output logic [31:0] r, output logic z,
                                output logic il, output int lat);
    int n;
    il  = 1'b0;
    n   = 0;
    case (c)
      4'd0:       r = a & b;
      4'd1:       r = a | b;
      4'd2:       r = a + b;
      4'd5, 4'd6: r = a - b;
      4'd7:       r = (a < b) ? 32'd1 : 32'd0;
      4'd8:       r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  begin r = $signed(b) >>> s;      n = int'(s);      end
      4'd10: begin r = $signed(b) >>> a[4:0]; n = int'(a[4:0]); end
      4'd11:      r = {b[15:0], 16'h0000};
      default: begin r = 32'h0; il = 1'b1; end
    endcase
    z = (c == 4'd5) ? (r != 32'h0) : (r == 32'h0);
`ifdef ALU_SEQ_BARREL_EN
    lat = 1;
`else
    lat = 1 + n;
`endif
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, input int hold);
    logic [31:0] er;
    logic        ez, ei;
    int          el, lat;
    model(c, a, b, s, er, ez, ei, el);
    check("idle_in_ready", bus.in_ready_o, 1);
    bus.in_valid_i = 1'b1;
    bus.ctrl_i     = c;
    bus.src1_i     = a;
    bus.src2_i     = b;
    bus.shamt_i    = s;
    @(posedge clk_i); #1;
    bus.in_valid_i = 1'b0;
    bus.ctrl_i     = 4'($urandom);
    bus.src1_i     = $urandom;
    bus.src2_i     = $urandom;
    bus.shamt_i    = 5'($urandom);
    lat = 1;
    while (!bus.out_valid_o && lat < 40) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check("latency", lat, el);
    check("result", bus.result_o, er);
    check("zero", bus.zero_o, ez);
    check("illegal", bus.illegal_o, ei);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid_i = 1'b1;
      bus.ctrl_i     = ALU_ADD;
      bus.src1_i     = $urandom;
      bus.src2_i     = $urandom;
      @(posedge clk_i); #1;
      check("hold_valid", bus.out_valid_o, 1);
      check("hold_in_ready", bus.in_ready_o, 0);
      check("hold_result", bus.result_o, er);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.out_ready_i = 1'b0;
    check("drain_valid", bus.out_valid_o, 0);
    check("idle_result_held", bus.result_o, er);
  endtask

  initial begin
    int seen;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.ctrl_i      = '0;
    bus.src1_i      = '0;
    bus.src2_i      = '0;
    bus.shamt_i     = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_in_ready", bus.in_ready_o, 1);
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_result", bus.result_o, 0);
    check("rst_zero", bus.zero_o, 0);
    check("rst_illegal", bus.illegal_o, 0);
    #3 rst_i = 1'b1;
    @(posedge clk_i); #1;

    run_op(ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0, 0);
    run_op(ALU_SUB,  32'h00000005, 32'h00000005, 5'd0, 3);
    run_op(ALU_BNE,  32'h00000005, 32'h00000005, 5'd0, 0);
    run_op(ALU_BNE,  32'h00000005, 32'h00000003, 5'd0, 0);
    run_op(ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0, 0);
    run_op(ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0, 0);
    run_op(ALU_LUI,  32'h00000000, 32'h0000ABCD, 5'd0, 0);
    run_op(ALU_SRA,  32'h00000000, 32'h80000000, 5'd4, 1);
    run_op(ALU_SRAV, 32'h00000000, 32'h12345678, 5'd0, 0);
    run_op(ALU_SRAV, 32'h0000001F, 32'h80000000, 5'd9, 0);
    run_op(4'b1111,  32'h12345678, 32'h9ABCDEF0, 5'd3, 0);
    run_op(ALU_OR,   32'h000000F0, 32'h0000000F, 5'd0, 0);
    run_op(ALU_AND,  32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0, 2);

    for (int k = 0; k < 40; k++)
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom),
             int'($urandom_range(0, 3)));

    // Reset in the middle of a 20-bit shift must drop the operation entirely.
    bus.in_valid_i = 1'b1;
    bus.ctrl_i     = ALU_SRA;
    bus.src1_i     = 32'h0;
    bus.src2_i     = 32'h80000000;
    bus.shamt_i    = 5'd20;
    @(posedge clk_i); #1;
    bus.in_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    check("midshift_rst_in_ready", bus.in_ready_o, 1);
    check("midshift_rst_out_valid", bus.out_valid_o, 0);
    check("midshift_rst_result", bus.result_o, 0);
    check("midshift_rst_zero", bus.zero_o, 0);
    check("midshift_rst_illegal", bus.illegal_o, 0);
    #1 rst_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i); #1;
      if (bus.out_valid_o) seen++;
    end
    check("midshift_no_valid", seen, 0);
    run_op(ALU_SUB, 32'h00000010, 32'h00000001, 5'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
